// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage for the single-cycle MIPS core. Holds the PC and a
//   word-addressed instruction memory, presents the current instruction to
//   execute combinationally, and computes the next PC from the branch/jump
//   controls that execute registers on the falling edge. A small run-control
//   FSM (IDLE -> RUN -> HALT) gates fetch, and a retired-instruction counter
//   supports bring-up.
//
// Ports
//   CLK          in   1    clock, all state updates on posedge
//   RST_N        in   1    asynchronous active-low reset
//   start        in   1    one-cycle pulse, IDLE/HALT -> RUN
//   branch       in   1    branch flag from execute
//   jump         in   1    jump flag from execute
//   zero         in   1    ALU zero flag from execute
//   imm16        in   16   signed branch offset in words
//   instr_index  in   26   jump target word index
//   imem_we      in   1    program-load write enable (ignored in RUN)
//   imem_waddr   in   AW   program-load word address
//   imem_wdata   in   32   program-load data
//   instr        out  32   instruction to execute (NOP_WORD unless fetching)
//   pc           out  32   current PC, byte address, always word aligned
//   running      out  1    FSM is in RUN
//   halted       out  1    FSM is in HALT
//   fault        out  1    sticky: PC left instruction memory
//   instr_count  out  32   instructions retired since the last start
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start,
  input  logic                     branch,
  input  logic                     jump,
  input  logic                     zero,
  input  logic [15:0]              imm16,
  input  logic [25:0]              instr_index,
  input  logic                     imem_we,
  input  logic [$clog2(DEPTH)-1:0] imem_waddr,
  input  logic [31:0]              imem_wdata,
  output logic [31:0]              instr,
  output logic [31:0]              pc,
  output logic                     running,
  output logic                     halted,
  output logic                     fault,
  output logic [31:0]              instr_count
);

  localparam int AW = $clog2(DEPTH);

  // A misaligned RESET_PC is truncated so pc[1:0] stays 00.
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_fault, w_fault_nxt;

  logic [31:0] r_imem [DEPTH];

  logic        w_in_range;
  logic [31:0] w_mem_word;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_target;

  // ---------------------------------------------------------------------------
  // Instruction memory. Writes are only accepted while fetch is stopped so a
  // running program can never be modified underneath itself.
  // NOTE: the memory array has no reset; program contents must survive RST_N,
  // and resetting a RAM would also prevent it mapping to a memory macro.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (imem_we && (r_state != ST_RUN)) begin
      r_imem[imem_waddr] <= imem_wdata;
    end
  end

  // Any PC bit above the word-index field being set means the PC has left
  // the memory; the word index alone would silently alias.
  assign w_in_range = ((r_pc >> (AW + 2)) == 32'd0);
  assign w_mem_word = r_imem[r_pc[AW+1:2]];

  // ---------------------------------------------------------------------------
  // Next-PC datapath. Jump wins over branch; branch arithmetic wraps at 32
  // bits. All candidates have 00 in the low bits, so alignment is implicit.
  // ---------------------------------------------------------------------------
  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    w_target = w_pc4;
    if (jump) begin
      w_target = {w_pc4[31:28], instr_index, 2'b00};
    end else if (branch && zero) begin
      w_target = w_pc4 + w_br_off;
    end
  end

  // ---------------------------------------------------------------------------
  // Run-control FSM: next state and next values of pc / count / fault.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_fault_nxt = r_fault;

    unique case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = START_PC;
          w_count_nxt = 32'd0;
          w_fault_nxt = 1'b0;
        end
      end

      ST_RUN: begin
        if (!w_in_range) begin
          // The NOP driven for the out-of-range fetch is not retired.
          w_state_nxt = ST_HALT;
          w_fault_nxt = 1'b1;
        end else if (w_mem_word == HALT_WORD) begin
          // HALT_WORD is not retired: pc keeps pointing at it.
          w_state_nxt = ST_HALT;
        end else begin
          w_pc_nxt    = w_target;
          w_count_nxt = r_count + 32'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_pc    <= START_PC;
      r_count <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Outside RUN, execute sees NOP_WORD so it latches branch=jump=0
  // before the first real fetch.
  // ---------------------------------------------------------------------------
  assign instr       = ((r_state == ST_RUN) && w_in_range) ? w_mem_word : NOP_WORD;
  assign pc          = r_pc;
  assign running     = (r_state == ST_RUN);
  assign halted      = (r_state == ST_HALT);
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule
